sram_axi_rd_slave: RTL

// AXI4 read-channel slave that serves host fetches of Ethernet packet data from the 16 KB packet SRAM.

---
 rtl/sram_axi_rd_slave.sv | 127 ++++++++++++
 1 files changed

// File: rtl/sram_axi_rd_slave.sv
// rtl/sram_axi_rd_slave.sv - AXI4 read-channel slave serving packet SRAM fetches
module sram_axi_rd_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ID_W      = 4,
  parameter int          DEPTH     = 2048
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [ID_W-1:0] s_arid,
  input  logic [31:0]     s_araddr,
  input  logic [7:0]      s_arlen,
  input  logic [2:0]      s_arsize,
  input  logic [1:0]      s_arburst,
  input  logic            s_arvalid,
  output logic            s_arready,
  output logic [ID_W-1:0] s_rid,
  output logic [63:0]     s_rdata,
  output logic [1:0]      s_rresp,
  output logic            s_rlast,
  output logic            s_rvalid,
  input  logic            s_rready,
  output logic            mem_read,
  output logic [31:0]     mem_rd_addr,
  input  logic [63:0]     mem_data_out
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] WIN_BYTES = 32'(8 * DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;

  logic [1:0]    state;
  logic [31:0]   ar_addr_q;
  logic [2:0]    ar_size_q;
  logic [1:0]    burst_q;
  logic [7:0]    len_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_hold_q;
  logic [8:0]    cnt_q;
  logic          err_q;
  logic          done_q;

  logic [31:0]   off;
  logic          bad_req;
  logic          load;
  logic          last_beat;

  // Request decode runs in SETUP from the latched AR fields, off the AR handshake path.
  assign off       = ar_addr_q - BASE_ADDR;
  assign bad_req   = (ar_addr_q < BASE_ADDR) || (off >= WIN_BYTES) ||
                     (ar_addr_q[2:0] != 3'd0) || (ar_size_q != 3'd3) || burst_q[1];
  assign load      = (state == ST_BURST) && !done_q && (!s_rvalid || s_rready);
  assign last_beat = (cnt_q == {1'b0, len_q});

  assign mem_read    = load && !err_q;
  assign mem_rd_addr = {{(32-AW){1'b0}}, (mem_read ? addr_q : addr_hold_q)};

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      s_arready   <= 1'b0;
      s_rvalid    <= 1'b0;
      s_rlast     <= 1'b0;
      s_rdata     <= '0;
      s_rresp     <= '0;
      s_rid       <= '0;
      ar_addr_q   <= '0;
      ar_size_q   <= '0;
      burst_q     <= '0;
      len_q       <= '0;
      addr_q      <= '0;
      addr_hold_q <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if (mem_read) begin
        addr_hold_q <= addr_q;
      end
      case (state)
        ST_IDLE: begin
          if (s_arvalid && s_arready) begin
            s_arready <= 1'b0;
            s_rid     <= s_arid;
            ar_addr_q <= s_araddr;
            ar_size_q <= s_arsize;
            burst_q   <= s_arburst;
            len_q     <= s_arlen;
            state     <= ST_SETUP;
          end else begin
            s_arready <= 1'b1;
          end
        end
        ST_SETUP: begin
          err_q  <= bad_req;
          addr_q <= off[AW+2:3];
          cnt_q  <= '0;
          done_q <= 1'b0;
          state  <= ST_BURST;
        end
        ST_BURST: begin
          if (load) begin
            s_rdata  <= err_q ? 64'd0 : mem_data_out;
            s_rresp  <= err_q ? 2'b10 : 2'b00;
            s_rvalid <= 1'b1;
            s_rlast  <= last_beat;
            done_q   <= last_beat;
            cnt_q    <= cnt_q + 1'b1;
            // FIXED bursts re-read the same word; INCR wraps at the top of the SRAM.
            if (burst_q == 2'b01) begin
              addr_q <= addr_q + 1'b1;
            end
          end else if (s_rvalid && s_rready && s_rlast) begin
            s_rvalid  <= 1'b0;
            s_rlast   <= 1'b0;
            s_arready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
